led_pattern_engine: RTL and testbench
=====================================

# led_pattern_engine

Parametrised LED pattern generator for the board LED bank: the next-generation holiday-lights block. It drives an N-LED pattern that advances once per programmable tick in one of four modes: rotate-left, rotate-right, bounce or blink. A single push-button sequences it through load/run/pause. It sits between the board switch/button pins and the LED pins, and contains its own button synchroniser and edge detector.

## Interface
- `N_LEDS`, default 16: number of LEDs driven; legal ≥ 2.
- `TICK_CYCLES`, default 100000000: clk cycles per pattern step; legal ≥ 2.
- `FILL_W`, default 3: width of the `switch` fill-count input.
- `clk` input 1: single clock for the whole block.
- `rst` input 1: reset, asynchronous, active-high; clears all state immediately.
- `button` input 1: raw push-button level, asynchronous to clk.
- `switch` input FILL_W: fill count minus one; sampled only in LOAD.
- `mode` input 2: pattern mode. 00 rotate-left, 01 rotate-right, 10 bounce, 11 blink. Sampled at every tick.
- `led` output N_LEDS: registered LED drive; bit 0 is the rightmost LED.
- `running` output 1: registered; 1 while in RUN.
- `state` output 2: registered FSM state. IDLE=00, LOAD=01, RUN=10, PAUSE=11.

## Operation
- **Button path**
  - Two-flop synchroniser, then a rising-edge detector, produces `press`: a one-cycle pulse per 0→1 transition.
  - A held button yields exactly one press.
  - No debounce; the board-level debouncer is upstream.
- **FSM**
  - IDLE: `led`=0. On press → LOAD.
  - LOAD: lasts exactly one cycle. Loads `pat` with the low F bits set, where F = min(switch+1, N_LEDS). Clears the tick counter, clears `blank`, sets `dir`=left. Then → RUN unconditionally.
  - RUN: the tick counter runs. On press → PAUSE.
  - PAUSE: pattern, counter, `dir` and `blank` are all frozen. On press → RUN (resume from the frozen point).
  - There is no path back to IDLE except `rst`.
- **Tick counter**
  - Width is clog2(TICK_CYCLES).
  - Increments only in RUN.
  - At TICK_CYCLES-1 it asserts `tick` and wraps to 0 on the same edge.
- **On tick in RUN**, by the `mode` value at that cycle:
  - 00: `pat` rotates left by 1 (MSB wraps to bit 0); `blank` cleared.
  - 01: `pat` rotates right by 1 (bit 0 wraps to MSB); `blank` cleared.
  - 10 (bounce):
    - `dir`=left: shift left, zero-fill. If `pat[N-1]`=1 before the shift, set `dir`=right and shift right instead.
    - `dir`=right: symmetric, using `pat[0]`.
    - If `pat` is all ones, it holds unchanged. `blank` cleared.
  - 11 (blink): `pat` unchanged; `blank` toggles.
- **LED output**: `led` = `blank` ? 0 : `pat`, registered, and updated on the same edge as `pat`/`blank`.
- **Mode change**: takes effect at the next tick only. Leaving blink while `blank`=1 un-blanks at that tick, with the shift applied on the same tick.
- **Simultaneous press and tick in RUN**: the press wins. Go to PAUSE with no shift; the counter holds at TICK_CYCLES-1, so the first RUN cycle after resume produces a tick.
- **Press in LOAD**: ignored (the pulse is lost).
- **`rst` at any time**: `state`=IDLE, `led`=0, `running`=0, counter=0, `pat`=0, `blank`=0, `dir`=left, synchroniser flops=0.

## Timing
- Button sampled high at edge t: the `state` change is visible after edge t+2.
- In IDLE, the press edge e loads LOAD. The `led`=fill pattern and `state`=RUN are visible after e+1.
- The first step is visible after edge e+1+TICK_CYCLES; subsequent steps follow every TICK_CYCLES cycles.
- `running` follows `state` with no extra latency (decoded from the next-state).
- Reset assertion is asynchronous; deassertion is assumed synchronous to clk (sync done upstream).

## Test plan
All scenarios use N_LEDS=8, TICK_CYCLES=4, FILL_W=3.
- **Reset/load/rotate**: rst, then switch=2, mode=00, one button pulse. `led`=0x07, then every 4 cycles 0x0E, 0x1C, …, 0xC1, 0x83, 0x07. `running`=1. Rotate-right gives 0x83 after the first tick.
- **Bounce**: switch=1, mode=10. Sequence is 0x03, 0x06, …, 0xC0, 0x60, …, 0x03, 0x06. With switch=7 in bounce, `led` stays 0xFF.
- **Blink, then mode switch**: switch=0, mode=11. `led` alternates 0x01/0x00 per tick. Switch to mode=00 while blanked; the next tick shows 0x02.
- **Pause/resume with collision**: press during RUN timed to the tick cycle. `state`=PAUSE and `led` holds for 20 cycles. Press again: the shift appears one cycle after entering RUN.
- **Held button and mid-run reset**: holding the button high for 50 cycles causes exactly one transition. Asserting rst mid-RUN clears `led` to 0x00 and `state` to IDLE within the same cycle, with no clock edge required.

Source files
------------

// File: rtl/led_pattern_engine_if.sv
// Board-side signal bundle for led_pattern_engine: button, fill switch and mode in,
// LED bank and FSM status out.
interface led_pattern_engine_if #(
   parameter int N_LEDS = 16,
   parameter int FILL_W = 3
);
   logic              button;
   logic [FILL_W-1:0] switch;
   logic [1:0]        mode;
   logic [N_LEDS-1:0] led;
   logic              running;
   logic [1:0]        state;

   modport master (output button, switch, mode, input led, running, state);
   modport slave  (input button, switch, mode, output led, running, state);
endinterface

// File: rtl/led_pattern_engine.sv
// N-LED pattern generator stepping once per TICK_CYCLES clocks in rotate/bounce/blink
// modes, sequenced IDLE -> LOAD -> RUN <-> PAUSE by a single synchronised push-button.
module led_pattern_engine #(
   parameter int N_LEDS      = 16,
   parameter int TICK_CYCLES = 100000000,
   parameter int FILL_W      = 3
) (
   input logic                 clk,
   input logic                 rst,
   led_pattern_engine_if.slave bus
);
   localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);
   localparam logic [N_LEDS-1:0] PAT_ZERO = {N_LEDS{1'b0}};
   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      LOAD  = 2'b01,
      RUN   = 2'b10,
      PAUSE = 2'b11
   } state_t;

   function automatic logic [N_LEDS-1:0] fill_mask(input logic [FILL_W-1:0] sw);
      logic [N_LEDS-1:0] m;
      m = PAT_ZERO;
      for (int i = 0; i < N_LEDS; i++) begin
         m[i] = (i <= int'(sw));
      end
      return m;
   endfunction

   logic              sync1_r, sync2_r, sync3_r;
   logic              press_s;
   state_t            state_r, next_state_s;
   logic              running_r;
   logic [CNT_W-1:0]  cnt_r, next_cnt_s;
   logic              tick_s;
   logic [N_LEDS-1:0] pat_r, next_pat_s;
   logic              blank_r, next_blank_s;
   logic              dir_r, next_dir_s;
   logic [N_LEDS-1:0] led_r;

   assign press_s = sync2_r & ~sync3_r;
   assign tick_s  = (cnt_r == CNT_LAST);

   // Two-flop synchroniser plus one history flop for rising-edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         sync3_r <= 1'b0;
      end else begin
         sync1_r <= bus.button;
         sync2_r <= sync1_r;
         sync3_r <= sync2_r;
      end
   end

   // Next-state logic; a press in LOAD is dropped on purpose
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (press_s) next_state_s = LOAD;
            else         next_state_s = IDLE;
         end
         LOAD: next_state_s = RUN;
         RUN: begin
            if (press_s) next_state_s = PAUSE;
            else         next_state_s = RUN;
         end
         PAUSE: begin
            if (press_s) next_state_s = RUN;
            else         next_state_s = PAUSE;
         end
         default: next_state_s = IDLE;
      endcase
   end

   // Pattern datapath; a press on the tick cycle pauses without stepping and keeps the counter at its last value
   always_comb begin
      next_cnt_s   = cnt_r;
      next_pat_s   = pat_r;
      next_blank_s = blank_r;
      next_dir_s   = dir_r;
      case (state_r)
         LOAD: begin
            next_cnt_s   = CNT_ZERO;
            next_pat_s   = fill_mask(bus.switch);
            next_blank_s = 1'b0;
            next_dir_s   = DIR_LEFT;
         end
         RUN: begin
            if (press_s) begin
               next_cnt_s = cnt_r;
            end else if (tick_s) begin
               next_cnt_s = CNT_ZERO;
               case (bus.mode)
                  2'b00: begin
                     next_pat_s   = {pat_r[N_LEDS-2:0], pat_r[N_LEDS-1]};
                     next_blank_s = 1'b0;
                  end
                  2'b01: begin
                     next_pat_s   = {pat_r[0], pat_r[N_LEDS-1:1]};
                     next_blank_s = 1'b0;
                  end
                  2'b10: begin
                     next_blank_s = 1'b0;
                     if (&pat_r) begin
                        next_pat_s = pat_r;
                     end else if (dir_r == DIR_LEFT) begin
                        if (pat_r[N_LEDS-1]) begin
                           next_dir_s = DIR_RIGHT;
                           next_pat_s = {1'b0, pat_r[N_LEDS-1:1]};
                        end else begin
                           next_pat_s = {pat_r[N_LEDS-2:0], 1'b0};
                        end
                     end else begin
                        if (pat_r[0]) begin
                           next_dir_s = DIR_LEFT;
                           next_pat_s = {pat_r[N_LEDS-2:0], 1'b0};
                        end else begin
                           next_pat_s = {1'b0, pat_r[N_LEDS-1:1]};
                        end
                     end
                  end
                  2'b11: next_blank_s = ~blank_r;
                  default: next_pat_s = pat_r;
               endcase
            end else begin
               next_cnt_s = cnt_r + CNT_ONE;
            end
         end
         default: next_cnt_s = cnt_r;
      endcase
   end

   // FSM state and running flag, both taken from the next-state so they change together
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         running_r <= 1'b0;
      end else begin
         state_r   <= next_state_s;
         running_r <= (next_state_s == RUN);
      end
   end

   // Pattern, tick counter, bounce direction, blank and LED drive
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r   <= CNT_ZERO;
         pat_r   <= PAT_ZERO;
         blank_r <= 1'b0;
         dir_r   <= DIR_LEFT;
         led_r   <= PAT_ZERO;
      end else begin
         cnt_r   <= next_cnt_s;
         pat_r   <= next_pat_s;
         blank_r <= next_blank_s;
         dir_r   <= next_dir_s;
         led_r   <= next_blank_s ? PAT_ZERO : next_pat_s;
      end
   end

   assign bus.led     = led_r;
   assign bus.running = running_r;
   assign bus.state   = state_r;
endmodule

// File: tb/tb_led_pattern_engine.sv
// Scoreboard bench for led_pattern_engine: stimulus queues each expected output change
// with its clock-edge number, and a monitor checks every observed change against it.
module tb_led_pattern_engine;
   localparam int N_LEDS = 8;
   localparam int TICK   = 4;
   localparam int FILL_W = 3;
   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_LOAD  = 2'b01;
   localparam logic [1:0] S_RUN   = 2'b10;
   localparam logic [1:0] S_PAUSE = 2'b11;

   typedef struct {
      int          cyc;
      logic [10:0] obs;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   int          cyc = 0;
   int          n_tests = 0;
   int          n_fail = 0;
   exp_t        exp_q[$];
   logic [7:0]  seq[$];
   logic [10:0] prev_obs = {8'h00, 2'b00, 1'b0};

   led_pattern_engine_if #(.N_LEDS(N_LEDS), .FILL_W(FILL_W)) bus ();

   led_pattern_engine #(
      .N_LEDS(N_LEDS),
      .TICK_CYCLES(TICK),
      .FILL_W(FILL_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic push(input int c, input logic [7:0] l, input logic [1:0] s, input logic r);
      exp_t x;
      x.cyc = c;
      x.obs = {l, s, r};
      exp_q.push_back(x);
   endtask

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h", name, got, want);
      end
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // button rises at the negedge of cycle d; the state change shows after edge d+3
   task automatic press(input int d, output int e);
      wait_cyc(d);
      bus.button = 1'b1;
      e = d + 3;
   endtask

   task automatic release_btn();
      repeat (2) @(negedge clk);
      bus.button = 1'b0;
   endtask

   task automatic load_run(input logic [2:0] sw, input logic [1:0] md,
                           input logic [7:0] fill, output int e);
      bus.switch = sw;
      bus.mode   = md;
      press(cyc + 1, e);
      push(e, 8'h00, S_LOAD, 1'b0);
      push(e + 1, fill, S_RUN, 1'b1);
      release_btn();
   endtask

   task automatic push_steps(input int e);
      foreach (seq[k]) push(e + 1 + TICK * (k + 1), seq[k], S_RUN, 1'b1);
   endtask

   task automatic hit_reset();
      @(negedge clk);
      #2;
      rst = 1'b1;
      push(cyc + 1, 8'h00, S_IDLE, 1'b0);
      #1;
      check("async_rst_led", bus.led, 8'h00);
      check("async_rst_state", {6'd0, bus.state}, 8'h00);
      check("async_rst_running", {7'd0, bus.running}, 8'h00);
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin : monitor
      logic [10:0] obs;
      exp_t        x;
      forever begin
         @(negedge clk);
         obs = {bus.led, bus.state, bus.running};
         if (obs !== prev_obs) begin
            prev_obs = obs;
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_change cyc=%0d actual led=%h state=%b running=%b required no change",
                        cyc, obs[10:3], obs[2:1], obs[0]);
            end else begin
               x = exp_q.pop_front();
               if (x.cyc != cyc || x.obs !== obs) begin
                  n_fail++;
                  $display("FAIL change actual cyc=%0d led=%h state=%b running=%b required cyc=%0d led=%h state=%b running=%b",
                           cyc, obs[10:3], obs[2:1], obs[0], x.cyc, x.obs[10:3], x.obs[2:1], x.obs[0]);
               end
            end
         end
      end
   end

   initial begin : stimulus
      int e, e2, e3;
      rst        = 1'b1;
      bus.button = 1'b0;
      bus.switch = 3'd0;
      bus.mode   = 2'b00;
      repeat (2) @(negedge clk);
      check("reset_led", bus.led, 8'h00);
      check("reset_state", {6'd0, bus.state}, 8'h00);
      check("reset_running", {7'd0, bus.running}, 8'h00);
      rst = 1'b0;

      // rotate-left full cycle, then reset mid-run
      load_run(3'd2, 2'b00, 8'h07, e);
      seq = '{8'h0E, 8'h1C, 8'h38, 8'h70, 8'hE0, 8'hC1, 8'h83, 8'h07};
      push_steps(e);
      wait_cyc(e + 1 + TICK * 8 + 2);
      hit_reset();

      // rotate-right
      load_run(3'd2, 2'b01, 8'h07, e);
      seq = '{8'h83, 8'hC1};
      push_steps(e);
      wait_cyc(e + 1 + TICK * 2 + 2);
      hit_reset();

      // bounce across both ends
      load_run(3'd1, 2'b10, 8'h03, e);
      seq = '{8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h60,
              8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h06};
      push_steps(e);
      wait_cyc(e + 1 + TICK * 13 + 2);
      hit_reset();

      // bounce with all LEDs lit holds still
      load_run(3'd7, 2'b10, 8'hFF, e);
      wait_cyc(e + 1 + TICK * 3 + 2);
      hit_reset();

      // blink, then switch to rotate-left while blanked
      load_run(3'd0, 2'b11, 8'h01, e);
      seq = '{8'h00, 8'h01, 8'h00};
      push_steps(e);
      wait_cyc(e + 14);
      bus.mode = 2'b00;
      push(e + 17, 8'h02, S_RUN, 1'b1);
      push(e + 21, 8'h04, S_RUN, 1'b1);
      wait_cyc(e + 23);
      hit_reset();

      // press collides with a tick, pause 20 cycles, resume
      load_run(3'd2, 2'b00, 8'h07, e);
      push(e + 5, 8'h0E, S_RUN, 1'b1);
      press(e + 6, e2);
      push(e2, 8'h0E, S_PAUSE, 1'b0);
      release_btn();
      press(e2 + 20, e3);
      push(e3, 8'h0E, S_RUN, 1'b1);
      push(e3 + 1, 8'h1C, S_RUN, 1'b1);
      push(e3 + 5, 8'h38, S_RUN, 1'b1);
      release_btn();
      wait_cyc(e3 + 7);
      hit_reset();

      // held button gives a single press
      bus.switch = 3'd7;
      bus.mode   = 2'b00;
      press(cyc + 1, e);
      push(e, 8'h00, S_LOAD, 1'b0);
      push(e + 1, 8'hFF, S_RUN, 1'b1);
      repeat (50) @(negedge clk);
      bus.button = 1'b0;
      repeat (12) @(negedge clk);

      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL missing_changes actual=%0d pending required=0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
